// File: rtl/ahbl_rr_arbiter_if.sv
// Address-phase request/grant bundle between the AHB-Lite
// master caches and the round-robin arbiter.
interface ahbl_rr_arbiter_if #(
  parameter int MM = 3
);
  localparam int SW = (MM > 1) ? $clog2(MM) : 1;

  logic [MM-1:0][1:0] HTRANS;
  logic [MM-1:0]      HMASTLOCK;
  logic               HREADY;
  logic [MM-1:0]      ARB_SEL;
  logic [SW-1:0]      MASTER_SEL;
  logic [MM-1:0]      ARB_SEL_PREV;
  logic [SW-1:0]      MASTER_SEL_PREV;

  modport master (
    output HTRANS,
    output HMASTLOCK,
    output HREADY,
    input  ARB_SEL,
    input  MASTER_SEL,
    input  ARB_SEL_PREV,
    input  MASTER_SEL_PREV
  );

  modport slave (
    input  HTRANS,
    input  HMASTLOCK,
    input  HREADY,
    output ARB_SEL,
    output MASTER_SEL,
    output ARB_SEL_PREV,
    output MASTER_SEL_PREV
  );
endinterface

// File: rtl/ahbl_rr_arbiter.sv
// Round-robin AHB-Lite arbiter with lock/burst hold and a
// per-owner NONSEQ quota; tracks the data-phase owner too.
module ahbl_rr_arbiter #(
  parameter int MM       = 3,
  parameter int MAX_HOLD = 4
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahbl_rr_arbiter_if.slave bus
);
  localparam int SW = (MM > 1) ? $clog2(MM) : 1;

  typedef enum logic [2:0] {
    D_LOCK,
    D_BURST,
    D_PARK,
    D_QUOTA,
    D_RR
  } dec_e;

  logic [SW-1:0] owner;
  logic [SW-1:0] prev;
  logic [7:0]    hold_cnt;

  logic [SW-1:0] owner_nxt;
  logic [7:0]    hold_nxt;
  logic [SW-1:0] rr_pick;
  logic          rr_found;

  logic [MM-1:0] req;
  logic [MM-1:0] own_oh;
  logic [MM-1:0] prev_oh;
  logic [1:0]    own_trans;
  logic          own_lock;
  logic          others;
  logic          own_burst;
  logic          own_nseq;
  logic          quota_ok;
  dec_e          dec;

  // One-hot decode of both registers and the owner's own request view
  always_comb begin
    own_oh    = '0;
    prev_oh   = '0;
    own_trans = 2'b00;
    own_lock  = 1'b0;
    for (int j = 0; j < MM; j++) begin
      req[j] = bus.HTRANS[j][1];
      if (owner == SW'(j)) begin
        own_oh[j] = 1'b1;
        own_trans = bus.HTRANS[j];
        own_lock  = bus.HMASTLOCK[j];
      end
      if (prev == SW'(j)) begin
        prev_oh[j] = 1'b1;
      end
    end
  end

  // First requester after the owner, wrapping at MM-1
  always_comb begin
    rr_pick  = owner;
    rr_found = 1'b0;
    for (int k = 1; k < MM; k++) begin
      if (!rr_found && req[(int'(owner) + k) % MM]) begin
        rr_pick  = SW'((int'(owner) + k) % MM);
        rr_found = 1'b1;
      end
    end
  end

  // Rule priority: lock, burst, park, quota, rotate
  always_comb begin
    others    = |(req & ~own_oh);
    own_burst = own_trans[0];
    own_nseq  = (own_trans == 2'b10);
    quota_ok  = ({1'b0, hold_cnt} + 9'd1) < 9'(MAX_HOLD);
    dec       = D_RR;
    if (own_lock) begin
      dec = D_LOCK;
    end else if (own_burst) begin
      dec = D_BURST;
    end else if (!others) begin
      dec = D_PARK;
    end else if (own_nseq && quota_ok) begin
      dec = D_QUOTA;
    end
  end

  // Next owner and quota count per decision
  always_comb begin
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    unique case (dec)
      D_LOCK,
      D_BURST: begin
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
      end
      D_PARK: begin
        owner_nxt = owner;
        hold_nxt  = 8'd0;
      end
      D_QUOTA: begin
        owner_nxt = owner;
        hold_nxt  = hold_cnt + 8'd1;
      end
      D_RR: begin
        owner_nxt = rr_pick;
        hold_nxt  = 8'd0;
      end
      default: begin
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
      end
    endcase
  end

  // Arbitrate only when the downstream bus accepts the address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner    <= '0;
      prev     <= '0;
      hold_cnt <= 8'd0;
    end else if (bus.HREADY) begin
      prev     <= owner;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign bus.ARB_SEL         = own_oh;
  assign bus.MASTER_SEL      = owner;
  assign bus.ARB_SEL_PREV    = prev_oh;
  assign bus.MASTER_SEL_PREV = prev;

endmodule

// File: tb/tb_ahbl_rr_arbiter.sv
// Scoreboard bench for ahbl_rr_arbiter: one instance with
// MAX_HOLD=1 (pure rotation) and one with MAX_HOLD=2.
module tb_ahbl_rr_arbiter;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;
  localparam int DR = 0;
  localparam int DQ = 1;

  typedef struct {
    int    dut;
    int    own;
    int    prv;
    string nm;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   tests;
  int   fails;
  exp_t sbq[$];

  exp_t       e;
  logic [1:0] ao;
  logic [1:0] ap;
  logic [2:0] aa;
  logic [2:0] aap;
  logic [2:0] wa;
  logic [2:0] wap;

  ahbl_rr_arbiter_if #(.MM(3)) ifr ();
  ahbl_rr_arbiter_if #(.MM(3)) ifq ();

  ahbl_rr_arbiter #(.MM(3), .MAX_HOLD(1)) u_rr (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (ifr)
  );

  ahbl_rr_arbiter #(.MM(3), .MAX_HOLD(2)) u_q (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (ifq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Monitor: compare every queued expectation on the falling edge
  always @(negedge HCLK) begin
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == DR) begin
        ao = ifr.MASTER_SEL; ap = ifr.MASTER_SEL_PREV;
        aa = ifr.ARB_SEL;    aap = ifr.ARB_SEL_PREV;
      end else begin
        ao = ifq.MASTER_SEL; ap = ifq.MASTER_SEL_PREV;
        aa = ifq.ARB_SEL;    aap = ifq.ARB_SEL_PREV;
      end
      wa  = 3'(1 << e.own);
      wap = 3'(1 << e.prv);
      tests++;
      if (ao !== 2'(e.own) || ap !== 2'(e.prv) ||
          aa !== wa || aap !== wap) begin
        fails++;
        $display("FAIL %s: got sel=%0d prev=%0d arb=%b arbp=%b, want sel=%0d prev=%0d arb=%b arbp=%b",
                 e.nm, ao, ap, aa, aap, e.own, e.prv, wa, wap);
      end
    end
  end

  task automatic set_r(input logic [1:0] t2, input logic [1:0] t1,
                       input logic [1:0] t0);
    ifr.HTRANS = {t2, t1, t0};
  endtask

  task automatic set_q(input logic [1:0] t2, input logic [1:0] t1,
                       input logic [1:0] t0, input logic [2:0] lk,
                       input logic rdy);
    ifq.HTRANS    = {t2, t1, t0};
    ifq.HMASTLOCK = lk;
    ifq.HREADY    = rdy;
  endtask

  task automatic push(input int d, input int eo, input int ep,
                      input string nm);
    exp_t x;
    x.dut = d; x.own = eo; x.prv = ep; x.nm = nm;
    sbq.push_back(x);
  endtask

  task automatic tick(input int d, input int eo, input int ep,
                      input string nm);
    @(posedge HCLK);
    #1;
    push(d, eo, ep, nm);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    HRESETn = 1'b0;
    set_r(I, I, I);
    ifr.HMASTLOCK = 3'b000;
    ifr.HREADY    = 1'b1;
    set_q(I, I, I, 3'b000, 1'b1);

    @(posedge HCLK);
    #1;
    push(DR, 0, 0, "reset_r");
    push(DQ, 0, 0, "reset_q");
    HRESETn = 1'b1;

    set_r(N, N, N);
    tick(DR, 1, 0, "rr_1");
    tick(DR, 2, 1, "rr_2");
    tick(DR, 0, 2, "rr_wrap");
    tick(DR, 1, 0, "rr_again");
    set_r(I, I, I);

    set_q(I, N, N, 3'b000, 1'b1);
    tick(DQ, 0, 0, "quota_keep");
    tick(DQ, 1, 0, "quota_sw");
    tick(DQ, 1, 1, "quota_m1keep");
    tick(DQ, 0, 1, "quota_back");
    tick(DQ, 0, 0, "quota_cnt1");
    set_q(I, I, N, 3'b000, 1'b1);
    tick(DQ, 0, 0, "alone_0");
    for (int i = 0; i < 3; i++) tick(DQ, 0, 0, "alone_n");
    set_q(I, N, N, 3'b000, 1'b1);
    tick(DQ, 0, 0, "cnt_cleared");
    tick(DQ, 1, 0, "quota_sw2");

    set_q(N, N, I, 3'b000, 1'b1);
    tick(DQ, 1, 1, "burst_nseq");
    set_q(N, S, I, 3'b000, 1'b1);
    tick(DQ, 1, 1, "burst_seq1");
    tick(DQ, 1, 1, "burst_seq2");
    tick(DQ, 1, 1, "burst_seq3");
    set_q(N, I, I, 3'b000, 1'b1);
    tick(DQ, 2, 1, "burst_end");

    set_q(I, N, I, 3'b010, 1'b1);
    tick(DQ, 1, 2, "lock_grant");
    set_q(N, N, I, 3'b010, 1'b1);
    for (int i = 0; i < 6; i++) tick(DQ, 1, 1, "lock_hold");
    set_q(N, N, I, 3'b000, 1'b1);
    tick(DQ, 1, 1, "unlock_quota");
    tick(DQ, 2, 1, "unlock_sw");

    set_q(I, I, N, 3'b000, 1'b1);
    tick(DQ, 0, 2, "ws_grant");
    set_q(N, I, I, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) tick(DQ, 0, 2, "ws_stable");
    set_q(N, I, I, 3'b000, 1'b1);
    tick(DQ, 2, 0, "ws_switch");

    set_q(I, N, N, 3'b000, 1'b1);
    tick(DQ, 0, 2, "wrap_to0");
    set_q(I, I, I, 3'b000, 1'b1);
    tick(DQ, 0, 0, "park_a");
    tick(DQ, 0, 0, "park_b");

    set_q(N, I, I, 3'b000, 1'b1);
    tick(DQ, 2, 0, "pre_rst_a");
    tick(DQ, 2, 2, "pre_rst_b");
    ifq.HREADY = 1'b0;
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    push(DQ, 0, 0, "rst_async_q");
    push(DR, 0, 0, "rst_async_r");
    @(posedge HCLK);
    #1;
    push(DQ, 0, 0, "rst_held");
    HRESETn = 1'b1;
    set_q(I, I, I, 3'b000, 1'b1);
    tick(DQ, 0, 0, "post_rst");

    @(negedge HCLK);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahbl_rr_arbiter.md
Name: ahbl_rr_arbiter

Overview:
Round-robin arbiter with transfer quota for the multi-master AHB-Lite bus mux. Selects which master's cached address phase drives the shared downstream port, and tracks the data-phase owner for HWDATA steering. Grants respect HMASTLOCK sequences and in-progress bursts. A per-owner quota counter bounds how long one master can hold the bus with back-to-back NONSEQ transfers while others wait.

Parameters:
MM, 3, number of masters; legal range 2..16.
MAX_HOLD, 4, max consecutive NONSEQ transfers the owner may issue while another master requests; legal range 1..255 (1 = pure round-robin).

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HTRANS  input  [MM-1:0][1:0]  per-master address-phase HTRANS (from aphase caches)
HMASTLOCK  input  [MM-1:0]  per-master address-phase HMASTLOCK
HREADY  input  1  downstream bus HREADY
ARB_SEL  output  [MM-1:0]  one-hot address-phase grant
MASTER_SEL  output  [$clog2(MM)-1:0]  encoded address-phase owner
ARB_SEL_PREV  output  [MM-1:0]  one-hot data-phase owner
MASTER_SEL_PREV  output  [$clog2(MM)-1:0]  encoded data-phase owner

Behaviour:
- Clock and reset: one clock, HCLK; reset is asynchronous and active-low, HRESETn.
- HTRANS encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. Master j requests when HTRANS[j][1]=1.
- Reset values: MASTER_SEL=0, ARB_SEL=1, MASTER_SEL_PREV=0, ARB_SEL_PREV=1, hold_cnt=0. Reset asserted mid-operation forces these immediately, regardless of HREADY.
- State: owner register (drives MASTER_SEL), prev register (drives MASTER_SEL_PREV), hold_cnt (8 bit).
- ARB_SEL and ARB_SEL_PREV are one-hot decodes of the registers. Exactly one bit is set at all times.
- Arbitration point: rising HCLK edge with HREADY=1.
  - On that edge: prev <= owner; owner <= next; hold_cnt updated as below.
  - With HREADY=0, all state holds. This gives wait-state stability of both SEL pairs.
- Latency: a new grant takes effect on the cycle after the arbitration point. A losing master's request stays held in its aphase cache.
- Let own = owner, others = any request from j != own. Next-owner rules, evaluated in priority order:
  1. HMASTLOCK[own]=1: keep own; hold_cnt unchanged.
  2. HTRANS[own] in {BUSY, SEQ}: burst in progress; keep own; hold_cnt unchanged.
  3. others=0: keep own (park on last owner); hold_cnt <= 0.
  4. HTRANS[own]=NONSEQ and hold_cnt+1 < MAX_HOLD: keep own; hold_cnt <= hold_cnt+1.
  5. Otherwise (own IDLE, or quota reached): owner <= first requester in the order own+1, own+2, ... modulo MM; hold_cnt <= 0.
- Simultaneous requests: resolved only by round-robin order relative to the current owner. No fixed priority.
- Wrap-around: search index wraps from MM-1 to 0. For non-power-of-two MM, encodings >= MM are never produced.
- Lock release: the first arbitration point where HMASTLOCK[own]=0 and HTRANS[own] is not BUSY/SEQ falls through to rules 3-5.
- hold_cnt never exceeds MAX_HOLD-1.

Test Plan:
- Reset: HRESETn=0 asynchronously mid-cycle while owner=2 -> MASTER_SEL=0, ARB_SEL=3'b001, MASTER_SEL_PREV=0, ARB_SEL_PREV=3'b001 immediately.
- Round-robin (MAX_HOLD=1, HREADY=1): all three masters hold NONSEQ -> MASTER_SEL sequence 0,1,2,0; MASTER_SEL_PREV lags by one cycle; ARB_SEL one-hot throughout.
- Quota (MAX_HOLD=2): m0 issues NONSEQ every cycle, m1 requests from cycle 0 -> m0 owns 2 cycles, MASTER_SEL=1 on cycle 2. With m1 idle, m0 keeps the bus indefinitely and hold_cnt stays 0.
- Burst and lock: m1 owns with NONSEQ,SEQ,SEQ,SEQ and m2 requests -> MASTER_SEL stays 1 through the last SEQ, then becomes 2. Repeat with HMASTLOCK[1]=1 over 6 NONSEQ (MAX_HOLD=2) -> no switch until the lock drops.
- Wait states: HREADY=0 for 3 cycles while m0 owns and m2 requests -> ARB_SEL, ARB_SEL_PREV, MASTER_SEL, MASTER_SEL_PREV all stable; switch to m2 on the first edge with HREADY=1.
- Wrap and park: owner=2 idle, m0 and m1 request -> next owner=0. Then all masters go IDLE -> owner stays 0 and hold_cnt=0.
